data_memory_arbiter: RTL
========================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 32, width of address and data buses.
REQ-002 SHALL have parameter WAIT_STATES, default 2, number of cycles the memory strobe is held per access (legal 1..15).
REQ-003 SHALL have port DataMemoryArbiter_CLOCK_50  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port DataMemoryArbiter_Reset_InHigh  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port DataMemoryArbiter_Req_A  input  1  requester A (control system) access request, level, held until Ack_A.
REQ-006 SHALL have port DataMemoryArbiter_WR_A  input  1  requester A: 1 = write, 0 = read.
REQ-007 SHALL have port DataMemoryArbiter_Address_A  input  DATAWIDTH_BUS  requester A address.
REQ-008 SHALL have port DataMemoryArbiter_Data_A  input  DATAWIDTH_BUS  requester A write data.
REQ-009 SHALL have ports DataMemoryArbiter_Req_B, _WR_B, _Address_B, _Data_B  input  1/1/DATAWIDTH_BUS/DATAWIDTH_BUS  same meaning for requester B (loader/debug port).
REQ-010 SHALL have ports DataMemoryArbiter_Ack_A, DataMemoryArbiter_Ack_B  output  1 each  one-cycle completion pulse per requester.
REQ-011 SHALL have port DataMemoryArbiter_RdData  output  DATAWIDTH_BUS  registered read data of last completed read.
REQ-012 SHALL have port DataMemoryArbiter_Busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have ports DataMemoryArbiter_Mem_Selector_RD, DataMemoryArbiter_Mem_Selector_WR  output  1 each  Data_Memory read/write strobes.
REQ-014 SHALL have ports DataMemoryArbiter_Mem_Address, DataMemoryArbiter_Mem_Data_Out  output  DATAWIDTH_BUS  latched address/write data to Data_Memory.
REQ-015 SHALL have port DataMemoryArbiter_Mem_Data_In  input  DATAWIDTH_BUS  Data_Memory read data.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE; all outputs registered.
REQ-017 IDLE: if any Req high at clock edge, SHALL grant one requester, latch its WR/Address/Data, load wait counter with WAIT_STATES-1, go to ACCESS; else stay IDLE.
REQ-018 Simultaneous Req_A and Req_B SHALL be resolved round-robin: grant the requester not granted last; last-granted flag resets to B (A wins first tie).
REQ-019 ACCESS: Mem_Selector_RD (read) or Mem_Selector_WR (write) SHALL be high for exactly WAIT_STATES cycles; counter decrements each cycle; at count 0 go to DONE.
REQ-020 For reads, RdData SHALL capture Mem_Data_In at the edge ending the last ACCESS cycle; writes SHALL leave RdData unchanged.
REQ-021 DONE: Ack of granted requester SHALL be high for exactly one cycle, strobes low, then return to IDLE unconditionally.
REQ-022 Latency: Req seen in IDLE cycle N -> ACCESS cycles N+1..N+WAIT_STATES -> Ack in cycle N+WAIT_STATES+1.
REQ-023 Req high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-024 Req dropped mid-access SHALL NOT abort; access completes and Ack pulses.
REQ-025 Ack_A and Ack_B SHALL never be high together; RD and WR strobes SHALL never be high together.
REQ-026 Address/data inputs changing during ACCESS SHALL NOT affect Mem_Address/Mem_Data_Out.

Reset
REQ-027 Reset SHALL immediately force IDLE, counter 0, last-granted = B, Busy/Ack_A/Ack_B/RD/WR = 0, RdData/Mem_Address/Mem_Data_Out = 0.
REQ-028 Reset during ACCESS SHALL abort the access with no Ack.

Configuration
REQ-029 With macro DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN defined, A SHALL always win ties; without it, round-robin per REQ-018.

Verification (WAIT_STATES=2)
REQ-030 Reset asserted mid-run -> all outputs 0 same cycle, Busy 0.
REQ-031 Req_A read addr 0x10, Mem_Data_In=0xDEADBEEF -> RD high 2 cycles with Mem_Address=0x10, Ack_A 3 cycles after request, RdData=0xDEADBEEF.
REQ-032 Req_A write 0x20/0x12345678 and Req_B write 0x24/0xCAFEF00D same cycle after reset -> A serviced first, then B; WR high 2 cycles each with correct address/data.
REQ-033 Req_A and Req_B held high 8 accesses -> grant order A,B,A,B,...; Ack never overlaps.
REQ-034 Reset pulsed in second ACCESS cycle -> RD/WR drop immediately, no Ack, next request serviced normally.
REQ-035 Macro defined, both Req held high -> only A serviced, Ack_B stays 0.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter in front of Data_Memory: latches one request, strobes RD/WR for WAIT_STATES cycles, then acks.
// Define DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN to make requester A win every tie instead of round-robin.
//
// state  | meaning
// IDLE   | waiting for Req_A/Req_B, grants and latches on the edge a request is seen
// ACCESS | memory strobe held, wait counter running down to 0
// DONE   | one-cycle Ack to the granted requester, strobes low
module data_memory_arbiter #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     DataMemoryArbiter_CLOCK_50,
  input  logic                     DataMemoryArbiter_Reset_InHigh,
  input  logic                     DataMemoryArbiter_Req_A,
  input  logic                     DataMemoryArbiter_WR_A,
  input  logic [DATAWIDTH_BUS-1:0] DataMemoryArbiter_Address_A,
  input  logic [DATAWIDTH_BUS-1:0] DataMemoryArbiter_Data_A,
  input  logic                     DataMemoryArbiter_Req_B,
  input  logic                     DataMemoryArbiter_WR_B,
  input  logic [DATAWIDTH_BUS-1:0] DataMemoryArbiter_Address_B,
  input  logic [DATAWIDTH_BUS-1:0] DataMemoryArbiter_Data_B,
  output logic                     DataMemoryArbiter_Ack_A,
  output logic                     DataMemoryArbiter_Ack_B,
  output logic [DATAWIDTH_BUS-1:0] DataMemoryArbiter_RdData,
  output logic                     DataMemoryArbiter_Busy,
  output logic                     DataMemoryArbiter_Mem_Selector_RD,
  output logic                     DataMemoryArbiter_Mem_Selector_WR,
  output logic [DATAWIDTH_BUS-1:0] DataMemoryArbiter_Mem_Address,
  output logic [DATAWIDTH_BUS-1:0] DataMemoryArbiter_Mem_Data_Out,
  input  logic [DATAWIDTH_BUS-1:0] DataMemoryArbiter_Mem_Data_In
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_t                   state;
  logic [3:0]               wait_cnt;
  logic                     cur_b;
  logic                     cur_wr;
  logic                     pick_b;
  logic                     sel_wr;
  logic [DATAWIDTH_BUS-1:0] sel_addr;
  logic [DATAWIDTH_BUS-1:0] sel_data;

`ifdef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
  assign pick_b = !DataMemoryArbiter_Req_A;
`else
  logic last_b;
  // On a tie, grant whoever was not granted last; last_b resets to B so A wins the first tie
  assign pick_b = DataMemoryArbiter_Req_B & (!DataMemoryArbiter_Req_A | !last_b);
`endif

  always_comb begin
    sel_wr   = DataMemoryArbiter_WR_A;
    sel_addr = DataMemoryArbiter_Address_A;
    sel_data = DataMemoryArbiter_Data_A;
    if (pick_b) begin
      sel_wr   = DataMemoryArbiter_WR_B;
      sel_addr = DataMemoryArbiter_Address_B;
      sel_data = DataMemoryArbiter_Data_B;
    end
  end

  always_ff @(posedge DataMemoryArbiter_CLOCK_50 or posedge DataMemoryArbiter_Reset_InHigh) begin
    if (DataMemoryArbiter_Reset_InHigh) begin
      state                             <= IDLE;
      wait_cnt                          <= '0;
      cur_b                             <= 1'b0;
      cur_wr                            <= 1'b0;
`ifndef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
      last_b                            <= 1'b1;
`endif
      DataMemoryArbiter_Ack_A           <= 1'b0;
      DataMemoryArbiter_Ack_B           <= 1'b0;
      DataMemoryArbiter_RdData          <= '0;
      DataMemoryArbiter_Busy            <= 1'b0;
      DataMemoryArbiter_Mem_Selector_RD <= 1'b0;
      DataMemoryArbiter_Mem_Selector_WR <= 1'b0;
      DataMemoryArbiter_Mem_Address     <= '0;
      DataMemoryArbiter_Mem_Data_Out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          DataMemoryArbiter_Ack_A <= 1'b0;
          DataMemoryArbiter_Ack_B <= 1'b0;
          if (DataMemoryArbiter_Req_A || DataMemoryArbiter_Req_B) begin
            cur_b                             <= pick_b;
            cur_wr                            <= sel_wr;
`ifndef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
            last_b                            <= pick_b;
`endif
            DataMemoryArbiter_Mem_Address     <= sel_addr;
            DataMemoryArbiter_Mem_Data_Out    <= sel_data;
            DataMemoryArbiter_Mem_Selector_RD <= !sel_wr;
            DataMemoryArbiter_Mem_Selector_WR <= sel_wr;
            DataMemoryArbiter_Busy            <= 1'b1;
            wait_cnt                          <= WAIT_LOAD;
            state                             <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            DataMemoryArbiter_Mem_Selector_RD <= 1'b0;
            DataMemoryArbiter_Mem_Selector_WR <= 1'b0;
            if (!cur_wr) begin
              DataMemoryArbiter_RdData <= DataMemoryArbiter_Mem_Data_In;
            end
            DataMemoryArbiter_Ack_A <= !cur_b;
            DataMemoryArbiter_Ack_B <= cur_b;
            state                   <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          DataMemoryArbiter_Ack_A <= 1'b0;
          DataMemoryArbiter_Ack_B <= 1'b0;
          DataMemoryArbiter_Busy  <= 1'b0;
          state                   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
